// File: rtl/conv_encoder_pkg.sv
// Shared definitions for the radix-4 convolutional encoder and its decoder-side users.
package conv_encoder_pkg;

  localparam int unsigned SLICED_INPUT_NUM = 6;
  localparam int unsigned RADIX            = 4;
  localparam int unsigned MAX_STATE_NUM    = 256;

  localparam int unsigned DEPTH_W    = 4;
  localparam int unsigned TAIL_CNT_W = 3;
  localparam int unsigned CFG_ADDR_W = 3;

  localparam logic [CFG_ADDR_W-1:0] CFG_DEPTH_ADDR = 3'd6;
  localparam logic [DEPTH_W-1:0]    DEPTH_RESET    = 4'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    FLUSH  = 2'd2
  } enc_state_t;

  // Only even memory depths from 2 to 8 describe a whole number of radix-4 steps.
  function automatic logic depth_legal(input logic [DEPTH_W-1:0] m);
    return (m == 4'd2) || (m == 4'd4) || (m == 4'd6) || (m == 4'd8);
  endfunction

endpackage

// File: rtl/conv_parity.sv
// Combinational parity bank: one coded bit per generator over the masked window.
module conv_parity #(
  parameter int unsigned SYM_W = 6,
  parameter int unsigned WIN_W = 10
) (
  input  logic [WIN_W-1:0]            window,
  input  logic [SYM_W-1:0][WIN_W-1:0] poly,
  output logic [SYM_W-1:0]            sym
);

  always_comb begin
    sym = '0;
    for (int j = 0; j < SYM_W; j++) begin
      sym[j] = ^(window & poly[j]);
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Radix-4 convolutional encoder with runtime depth/generators and zero-tail termination.
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter int unsigned SYM_W = SLICED_INPUT_NUM,
  parameter int unsigned IN_W  = $clog2(RADIX),
  parameter int unsigned ST_W  = $clog2(MAX_STATE_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_enc,
  input  logic                   i_cfg_we,
  input  logic [CFG_ADDR_W-1:0]  i_cfg_addr,
  input  logic [IN_W+ST_W-1:0]   i_cfg_data,
  input  logic                   i_valid,
  input  logic [IN_W-1:0]        i_data,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [SYM_W-1:0]       o_sym,
  output logic                   o_last,
  input  logic                   i_ready,
  output logic [ST_W-1:0]        o_state,
  output logic                   o_busy
);

  localparam int unsigned WIN_W = IN_W + ST_W;

  enc_state_t              fsm_q, fsm_d;
  logic [ST_W-1:0]         state_q;
  logic [DEPTH_W-1:0]      depth_q;
  logic [WIN_W-1:0]        poly_q [SYM_W];
  logic [TAIL_CNT_W-1:0]   tail_q, tail_d;

  logic                    out_free;
  logic                    fire;
  logic                    tail_step;
  logic                    step;
  logic                    last_d;
  logic                    flush_done;
  logic                    cfg_open;
  logic [IN_W-1:0]         step_in;
  logic [ST_W-1:0]         mask;
  logic [ST_W-1:0]         next_state;
  logic [SYM_W-1:0][WIN_W-1:0] poly_m;
  logic [SYM_W-1:0]        sym;

  // Handshake: the single output register may load when empty or being drained.
  assign out_free  = !o_valid || i_ready;
  assign o_ready   = rst && en_enc && ((fsm_q == IDLE) || (fsm_q == ENCODE)) && out_free;
  assign fire      = i_valid && o_ready;
  assign tail_step = en_enc && (fsm_q == FLUSH) && out_free;
  assign step      = fire || tail_step;
  assign step_in   = (fsm_q == FLUSH) ? '0 : i_data;
  assign cfg_open  = i_cfg_we && en_enc && (fsm_q == IDLE);

  always_comb begin
    mask = '0;
    for (int b = 0; b < ST_W; b++) begin
      mask[b] = (DEPTH_W'(b) < depth_q);
    end
  end

  always_comb begin
    for (int j = 0; j < SYM_W; j++) begin
      poly_m[j] = poly_q[j] & {{IN_W{1'b1}}, mask};
    end
  end

  assign next_state = ((state_q << IN_W) | ST_W'(step_in)) & mask;

  conv_parity #(
    .SYM_W (SYM_W),
    .WIN_W (WIN_W)
  ) u_parity (
    .window ({step_in, state_q}),
    .poly   (poly_m),
    .sym    (sym)
  );

  // Frame sequencing and tail count.
  always_comb begin
    fsm_d      = fsm_q;
    tail_d     = tail_q;
    last_d     = 1'b0;
    flush_done = 1'b0;
    case (fsm_q)
      IDLE, ENCODE: begin
        if (fire) begin
          fsm_d = ENCODE;
          if (i_last) begin
            fsm_d  = FLUSH;
            tail_d = TAIL_CNT_W'(depth_q >> 1);
          end
        end
      end
      FLUSH: begin
        if (tail_step) begin
          tail_d = tail_q - TAIL_CNT_W'(1);
          if (tail_q == TAIL_CNT_W'(1)) begin
            last_d     = 1'b1;
            flush_done = 1'b1;
            fsm_d      = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      tail_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      tail_q <= tail_d;
    end
  end

  // Shift register and output stage advance together, so o_state tracks o_sym.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      o_valid <= 1'b0;
      o_sym   <= '0;
      o_last  <= 1'b0;
    end else begin
      if (step) begin
        state_q <= flush_done ? '0 : next_state;
        o_valid <= 1'b1;
        o_sym   <= sym;
        o_last  <= last_d;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_q <= DEPTH_RESET;
      for (int j = 0; j < SYM_W; j++) begin
        poly_q[j] <= '0;
      end
    end else if (cfg_open) begin
      for (int j = 0; j < SYM_W; j++) begin
        if (i_cfg_addr == CFG_ADDR_W'(j)) begin
          poly_q[j] <= i_cfg_data;
        end
      end
      if (i_cfg_addr == CFG_DEPTH_ADDR && depth_legal(i_cfg_data[DEPTH_W-1:0])) begin
        depth_q <= i_cfg_data[DEPTH_W-1:0];
      end
    end
  end

  assign o_state = state_q;
  assign o_busy  = (fsm_q != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// Directed scoreboard bench for conv_encoder: a bit-level reference model feeds the expected-symbol queue.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_enc = 1'b1;
  logic       i_cfg_we = 1'b0;
  logic [2:0] i_cfg_addr = '0;
  logic [9:0] i_cfg_data = '0;
  logic       i_valid = 1'b0;
  logic [1:0] i_data = '0;
  logic       i_last = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready;
  logic       o_valid;
  logic [5:0] o_sym;
  logic       o_last;
  logic [7:0] o_state;
  logic       o_busy;

  conv_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .en_enc     (en_enc),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_data (i_cfg_data),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_sym      (o_sym),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_state    (o_state),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sym;
    logic       last;
    logic [7:0] st;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         pops = 0;
  int         lasts = 0;
  int         p0, l0;
  logic [7:0] m_state;
  int         m_depth;
  logic [9:0] m_poly [6];
  logic [5:0] snap_sym;
  logic [7:0] snap_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference step: window bit b contributes when it is an input bit or a live state bit.
  task automatic model_push(input logic [1:0] din, input logic last);
    logic [9:0] w;
    logic [7:0] msk;
    exp_t       e;
    w = {din, m_state};
    for (int b = 0; b < 8; b++) msk[b] = (b < m_depth);
    for (int j = 0; j < 6; j++) begin
      e.sym[j] = 1'b0;
      for (int b = 0; b < 10; b++) begin
        if (b >= 8 || msk[b]) e.sym[j] = e.sym[j] ^ (w[b] & m_poly[j][b]);
      end
    end
    m_state = ((m_state << 2) | {6'b0, din}) & msk;
    e.last  = last;
    e.st    = m_state;
    sb.push_back(e);
  endtask

  task automatic fire_pair(input logic [1:0] d, input logic last);
    bit ok;
    ok = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL fire_timeout observed o_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [1:0] d, input logic last);
    model_push(d, 1'b0);
    fire_pair(d, last);
    if (last) begin
      for (int k = 0; k < m_depth / 2; k++) model_push(2'b00, k == m_depth / 2 - 1);
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [9:0] d);
    i_cfg_we   = 1'b1;
    i_cfg_addr = a;
    i_cfg_data = d;
    @(posedge clk);
    #1;
    i_cfg_we   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_valid) break;
    end
    check({tag, "_queue"}, 32'(sb.size()), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_state"}, 32'(o_state), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on every accepted symbol.
  always @(negedge clk) begin
    if (rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_sym observed %0h expected none", o_sym);
      end else begin
        mon_e = sb.pop_front();
        pops++;
        if (o_last) lasts++;
        check("sym", 32'(o_sym), 32'(mon_e.sym));
        check("last", 32'(o_last), 32'(mon_e.last));
        check("sym_state", 32'(o_state), 32'(mon_e.st));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_state = '0;
    m_depth = 2;
    for (int j = 0; j < 6; j++) m_poly[j] = '0;

    #12;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_sym", 32'(o_sym), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Basic encode against literal symbols.
    cfg(3'd0, 10'h200); cfg(3'd1, 10'h100); cfg(3'd2, 10'h002);
    cfg(3'd3, 10'h001); cfg(3'd4, 10'h300); cfg(3'd5, 10'h003);
    cfg(3'd6, 10'h002);
    m_poly[0] = 10'h200; m_poly[1] = 10'h100; m_poly[2] = 10'h002;
    m_poly[3] = 10'h001; m_poly[4] = 10'h300; m_poly[5] = 10'h003;
    p0 = pops;
    sb.push_back({6'b000011, 1'b0, 8'h03});
    sb.push_back({6'b011110, 1'b0, 8'h01});
    sb.push_back({6'b101000, 1'b1, 8'h00});
    fire_pair(2'b11, 1'b0);
    check("basic_busy", 32'(o_busy), 32'd1);
    fire_pair(2'b01, 1'b1);
    idle();
    drain("basic");
    check("basic_count", 32'(pops - p0), 32'd3);

    // Illegal depth ignored; denser generators.
    cfg(3'd6, 10'h005);
    cfg(3'd0, 10'h2A5); cfg(3'd1, 10'h1C3); cfg(3'd2, 10'h36F);
    cfg(3'd3, 10'h0F1); cfg(3'd4, 10'h3B8); cfg(3'd5, 10'h257);
    m_poly[0] = 10'h2A5; m_poly[1] = 10'h1C3; m_poly[2] = 10'h36F;
    m_poly[3] = 10'h0F1; m_poly[4] = 10'h3B8; m_poly[5] = 10'h257;
    p0 = pops;
    send_pair(2'b10, 1'b0);
    send_pair(2'b01, 1'b0);
    send_pair(2'b11, 1'b0);
    send_pair(2'b00, 1'b1);
    idle();
    drain("depth_guard");
    check("depth_guard_count", 32'(pops - p0), 32'd5);

    // Backpressure mid-frame.
    send_pair(2'b01, 1'b0);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 2'b10;
    @(negedge clk);
    snap_sym   = o_sym;
    snap_state = o_state;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_sym", 32'(o_sym), 32'(snap_sym));
      check("bp_state", 32'(o_state), 32'(snap_state));
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send_pair(2'b10, 1'b0);
    send_pair(2'b11, 1'b1);
    idle();
    drain("bp");

    // Depth 8: three pairs plus four tail symbols.
    cfg(3'd6, 10'h008);
    m_depth = 8;
    p0 = pops;
    l0 = lasts;
    send_pair(2'b11, 1'b0);
    send_pair(2'b10, 1'b0);
    send_pair(2'b01, 1'b1);
    idle();
    drain("m8");
    check("m8_count", 32'(pops - p0), 32'd7);
    check("m8_last_count", 32'(lasts - l0), 32'd1);

    // Generator write while encoding is dropped.
    send_pair(2'b10, 1'b0);
    idle();
    cfg(3'd0, 10'h3FF);
    check("cfg_busy", 32'(o_busy), 32'd1);
    send_pair(2'b01, 1'b0);
    send_pair(2'b11, 1'b1);
    idle();
    drain("cfg_guard");

    // Single-pair frame at depth 4.
    cfg(3'd6, 10'h004);
    m_depth = 4;
    p0 = pops;
    send_pair(2'b10, 1'b1);
    idle();
    check("single_busy", 32'(o_busy), 32'd1);
    drain("single");
    check("single_count", 32'(pops - p0), 32'd3);

    // Disabled block takes no input.
    en_enc  = 1'b0;
    i_valid = 1'b1;
    i_data  = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dis_ready", 32'(o_ready), 32'd0);
      check("dis_valid", 32'(o_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    idle();
    en_enc = 1'b1;

    // Reset in mid-frame restores defaults.
    send_pair(2'b11, 1'b0);
    send_pair(2'b01, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_state", 32'(o_state), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    sb.delete();
    m_state = '0;
    m_depth = 2;
    for (int j = 0; j < 6; j++) m_poly[j] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(o_ready), 32'd1);
    p0 = pops;
    send_pair(2'b11, 1'b1);
    idle();
    drain("post_rst");
    check("post_rst_count", 32'(pops - p0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
